dmem_ctrl: RTL

// Parametrised single-port data memory with valid/ready request channel,

---
 rtl/dmem_pkg.sv | 15 +
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_ctrl.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and address helpers for the data-memory controller.
package dmem_pkg;

    typedef enum logic [1:0] {INIT, IDLE, WAIT, RESP} state_t;

    // Byte-lane geometry of the default 32-bit word.
    localparam int unsigned BE_W  = 4;
    localparam int unsigned OFF_W = $clog2(BE_W);

    // Word index of a byte address for a word of 2**off_w bytes.
    function automatic logic [63:0] word_idx(input logic [63:0] addr, input int unsigned off_w);
        return addr >> off_w;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_W storage: byte-enabled synchronous write, combinational read.
module dmem_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned IDX_W  = 4
) (
    input  logic                clk,
    input  logic                we,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] wbe,
    input  logic [IDX_W-1:0]    raddr,
    output logic [DATA_W-1:0]   rdata_c
);

    localparam int unsigned LANES = DATA_W / 8;

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int k = 0; k < int'(LANES); k++) begin
                if (wbe[k]) mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
            end
        end
    end

    assign rdata_c = mem[raddr];

endmodule

// File: rtl/dmem_ctrl.sv
// Single-port data memory with valid/ready requests, byte-enabled stores,
// programmable response latency and a post-reset self-fill.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DATA_W    = 8 * BE_W,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned ADDR_W    = 32,
    parameter int unsigned LATENCY   = 1,
    parameter int unsigned INIT_MODE = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_write,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_be,
    output logic                rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                init_done
);

    localparam int unsigned LANES    = DATA_W / 8;
    localparam int unsigned OFF_BITS = $clog2(LANES);
    localparam int unsigned IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned LAT_W    = 3;

    state_t            state, state_n;
    logic [IDX_W-1:0]  init_cnt, init_cnt_n;
    logic [LAT_W-1:0]  lat_cnt, lat_cnt_n;
    logic              wr_q, wr_n;
    logic [ADDR_W-1:0] addr_q, addr_n;
    logic [DATA_W-1:0] wdata_q, wdata_n;
    logic [LANES-1:0]  be_q, be_n;
    logic              ready_n, valid_n, err_n, done_n;
    logic [DATA_W-1:0] rdata_n;
    logic              do_access;

    logic              acc_wr_c;
    logic [ADDR_W-1:0] acc_addr_c, acc_idx_c;
    logic [DATA_W-1:0] acc_wdata_c;
    logic [LANES-1:0]  acc_be_c;
    logic              acc_err_c;

    logic              arr_we_c;
    logic [IDX_W-1:0]  arr_waddr_c;
    logic [DATA_W-1:0] arr_wdata_c, arr_rdata_c;
    logic [LANES-1:0]  arr_be_c;

    // A zero-latency access happens on the accept edge, so it uses the live request.
    assign acc_wr_c    = (state == IDLE) ? req_write : wr_q;
    assign acc_addr_c  = (state == IDLE) ? req_addr  : addr_q;
    assign acc_wdata_c = (state == IDLE) ? req_wdata : wdata_q;
    assign acc_be_c    = (state == IDLE) ? req_be    : be_q;

    assign acc_idx_c = ADDR_W'(word_idx(64'(acc_addr_c), OFF_BITS));
    assign acc_err_c = ((acc_addr_c & ADDR_W'(LANES - 1)) != '0) ||
                       (acc_idx_c >= ADDR_W'(DEPTH));

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk     (clk),
        .we      (arr_we_c),
        .waddr   (arr_waddr_c),
        .wdata   (arr_wdata_c),
        .wbe     (arr_be_c),
        .raddr   (acc_idx_c[IDX_W-1:0]),
        .rdata_c (arr_rdata_c)
    );

    always_comb begin
        state_n     = state;
        init_cnt_n  = init_cnt;
        lat_cnt_n   = lat_cnt;
        wr_n        = wr_q;
        addr_n      = addr_q;
        wdata_n     = wdata_q;
        be_n        = be_q;
        rdata_n     = rsp_rdata;
        err_n       = rsp_err;
        done_n      = init_done;
        do_access   = 1'b0;
        arr_we_c    = 1'b0;
        arr_waddr_c = init_cnt;
        arr_wdata_c = (INIT_MODE != 0) ? DATA_W'(init_cnt) : '0;
        arr_be_c    = '1;

        unique case (state)
            INIT: begin
                arr_we_c = 1'b1;
                if (init_cnt == IDX_W'(DEPTH - 1)) begin
                    state_n = IDLE;
                    done_n  = 1'b1;
                end else begin
                    init_cnt_n = init_cnt + 1'b1;
                end
            end
            IDLE: begin
                if (req_valid) begin
                    wr_n    = req_write;
                    addr_n  = req_addr;
                    wdata_n = req_wdata;
                    be_n    = req_be;
                    if (LATENCY == 0) begin
                        state_n   = RESP;
                        do_access = 1'b1;
                    end else begin
                        state_n   = WAIT;
                        lat_cnt_n = LAT_W'(LATENCY);
                    end
                end
            end
            WAIT: begin
                if (lat_cnt == LAT_W'(1)) begin
                    state_n   = RESP;
                    do_access = 1'b1;
                end else begin
                    lat_cnt_n = lat_cnt - 1'b1;
                end
            end
            RESP: state_n = IDLE;
            default: state_n = INIT;
        endcase

        // Commit the access on the transition into RESP.
        if (do_access) begin
            err_n   = acc_err_c;
            rdata_n = (!acc_err_c && !acc_wr_c) ? arr_rdata_c : '0;
            if (acc_wr_c && !acc_err_c) begin
                arr_we_c    = 1'b1;
                arr_waddr_c = acc_idx_c[IDX_W-1:0];
                arr_wdata_c = acc_wdata_c;
                arr_be_c    = acc_be_c;
            end
        end
    end

    assign ready_n = (state_n == IDLE);
    assign valid_n = (state_n == RESP);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= INIT;
            init_cnt  <= '0;
            lat_cnt   <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            req_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            init_done <= 1'b0;
        end else begin
            state     <= state_n;
            init_cnt  <= init_cnt_n;
            lat_cnt   <= lat_cnt_n;
            wr_q      <= wr_n;
            addr_q    <= addr_n;
            wdata_q   <= wdata_n;
            be_q      <= be_n;
            req_ready <= ready_n;
            rsp_valid <= valid_n;
            rsp_rdata <= rdata_n;
            rsp_err   <= err_n;
            init_done <= done_n;
        end
    end

endmodule
